bcd_angle_stepper: RTL and testbench
====================================

Name: bcd_angle_stepper

Overview:
- Inverse of the position-code-to-BCD decoder: accepts a target angle as three serial BCD digits (hundreds, tens, ones) over a valid/ready handshake.
- Validates the angle as one of the eight 45° sectors and walks the 3-bit Gray position code (`one_hot`) one sector per `step_tick` until it reaches the target.
- Drives sector-indexed actuators/indicators from the same code space the decoder consumes.

Parameters:
- SHORTEST, 1, 1 = rotate in the shorter direction (tie at 4 sectors → increment); 0 = always increment.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- digit_valid  in  1  BCD digit present on `digit`
- digit  in  4  BCD digit; order is hundreds, tens, ones
- digit_ready  out  1  block accepts a digit this cycle
- step_tick  in  1  single-cycle step enable (one sector per tick)
- one_hot  out  3  current position, Gray code
- degrees  out  9  current angle in degrees, 45 × index
- busy  out  1  command in progress (state ≠ IDLE)
- done  out  1  one-cycle pulse: target reached
- err  out  1  one-cycle pulse: command rejected

Behaviour:
- Only one clock and one reset: `clk`, `rst`. Reset is synchronous and active-high.
- Position index mapping, idx 0..7:
  - `degrees` = 45·idx.
  - `one_hot` = idx ^ (idx>>1): 000, 001, 011, 010, 110, 111, 101, 100 for 0°, 45°, 90°, 135°, 180°, 225°, 270°, 315°.
  - `one_hot` and `degrees` are registered and always consistent.
- Reset values:
  - state IDLE, idx 0, so `one_hot` 000 and `degrees` 0.
  - digit count 0, bad-digit flag 0.
  - `done` 0, `err` 0, `busy` 0, `digit_ready` 1.
- States: IDLE, CHECK, MOVE.
- `digit_ready` = (state == IDLE). `busy` = (state != IDLE). Both are combinational from state.
- IDLE:
  - A digit is accepted on `digit_valid && digit_ready`.
  - Digits store into h, t, o by count 0, 1, 2.
  - Any digit > 9 sets a sticky bad flag.
  - Acceptance of the third digit → CHECK; the count clears.
- CHECK (exactly one cycle):
  - value = h·100 + t·10 + o, 10-bit unsigned.
  - Valid iff bad flag = 0, value ≤ 315, and value mod 45 = 0. Then tgt = value/45.
  - Invalid: `err` ← 1 for one cycle, position unchanged, bad flag clears, → IDLE.
  - Valid and tgt == idx: `done` ← 1 for one cycle, → IDLE. No tick is needed.
  - Valid otherwise: latch tgt and direction, → MOVE.
- Direction:
  - diff = (tgt − idx) mod 8.
  - SHORTEST=1: increment if diff ≤ 4, else decrement.
  - SHORTEST=0: always increment.
  - Direction is fixed for the whole move.
- MOVE:
  - On each cycle with `step_tick` = 1, idx ← idx ± 1 mod 8. Wraps 7↔0, i.e. 315°↔0°.
  - On the step that makes idx == tgt: `done` ← 1 in the same edge, → IDLE.
  - `done` is therefore high in the first cycle `one_hot` shows the target.
  - Cycles without `step_tick` hold position.
- Ignored inputs:
  - `digit_valid` outside IDLE is ignored (not accepted, not queued).
  - `step_tick` outside MOVE is ignored.
- Pulse rules: `done` and `err` are never high together. Each is high for exactly one cycle per command.
- A new command may start in the cycle `done` or `err` is high, since state is already IDLE.
- `rst` mid-command (any state) aborts immediately:
  - all reset values are restored next cycle, including position 000/0.
  - a partial digit entry is discarded.
- Latency:
  - third digit accepted at edge k → CHECK result at edge k+1.
  - MOVE needs |steps| ticks.

Test Plan:
- Reset, then idle → `one_hot`=000, `degrees`=0, `digit_ready`=1, `busy`=0, `done`=`err`=0.
- From 0°, digits 1,3,5, `step_tick` every cycle → `one_hot` 001, 011, 010 on successive ticks; `done` with 010 / 135; exactly 3 steps.
- Wrap and direction (SHORTEST=1):
  - From 315° (100), enter 0,4,5 → 000 then 001; `done` at 45.
  - Then enter 2,7,0 → decrement: 000, 100, 101; `done` at 270.
  - SHORTEST=0 from 45° to 270° → 011, 010, 110, 111, 101 (5 steps).
- Rejections, each giving `err` pulse for 1 cycle and `one_hot` unchanged, followed by an immediate valid command that works:
  - 1,0,0 (not multiple of 45)
  - 3,6,0 (>315)
  - 0,12,0 (non-BCD)
- Same target: at 180° enter 1,8,0 → `done` one cycle after CHECK with zero ticks, no position change.
- Robustness:
  - Hold `digit_valid` during MOVE → no digits consumed.
  - Ticks while IDLE → no motion.
  - Assert `rst` after 2 of 5 steps → next cycle 000 / 0, IDLE, `done`=0.

Source files
------------

// File: rtl/bcd_angle_stepper.sv
// rtl/bcd_angle_stepper.sv - serial BCD angle command to Gray-coded 45-degree sector stepper
module bcd_angle_stepper #(
   parameter bit SHORTEST = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       digit_valid,
   input  logic [3:0] digit,
   output logic       digit_ready,
   input  logic       step_tick,
   output logic [2:0] one_hot,
   output logic [8:0] degrees,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CHECK,
      S_MOVE
   } state_t;

   state_t     r_state, w_state_nxt;
   logic [2:0] r_idx, w_idx_nxt;
   logic [2:0] r_tgt, w_tgt_nxt;
   logic       r_inc, w_inc_nxt;
   logic [1:0] r_cnt, w_cnt_nxt;
   logic       r_bad, w_bad_nxt;
   logic [3:0] r_h, w_h_nxt;
   logic [3:0] r_t, w_t_nxt;
   logic [3:0] r_o, w_o_nxt;
   logic       w_done_nxt, w_err_nxt;
   logic [2:0] r_one_hot;
   logic [8:0] r_degrees;
   logic       r_done, r_err;

   logic [9:0] w_value;
   logic       w_hit;
   logic [2:0] w_value_tgt;
   logic [2:0] w_diff;
   logic       w_dir_inc;
   logic [2:0] w_idx_step;

   function automatic logic [2:0] f_gray(input logic [2:0] i_idx);
      return i_idx ^ (i_idx >> 1);
   endfunction

   function automatic logic [8:0] f_degrees(input logic [2:0] i_idx);
      return {6'd0, i_idx} * 9'd45;
   endfunction

   assign w_value = ({6'd0, r_h} * 10'd100) + ({6'd0, r_t} * 10'd10) + {6'd0, r_o};

   // A match against one of the eight sector angles covers both the range and the mod-45 test.
   always_comb begin
      w_hit       = 1'b0;
      w_value_tgt = 3'd0;
      for (int k = 0; k < 8; k++) begin
         if (w_value == 10'(45 * k)) begin
            w_hit       = 1'b1;
            w_value_tgt = 3'(k);
         end
      end
   end

   assign w_diff     = w_value_tgt - r_idx;
   assign w_dir_inc  = !SHORTEST || (w_diff <= 3'd4);
   assign w_idx_step = r_inc ? (r_idx + 3'd1) : (r_idx - 3'd1);

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_tgt_nxt   = r_tgt;
      w_inc_nxt   = r_inc;
      w_cnt_nxt   = r_cnt;
      w_bad_nxt   = r_bad;
      w_h_nxt     = r_h;
      w_t_nxt     = r_t;
      w_o_nxt     = r_o;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (digit_valid) begin
               case (r_cnt)
                  2'd0:    w_h_nxt = digit;
                  2'd1:    w_t_nxt = digit;
                  default: w_o_nxt = digit;
               endcase
               if (digit > 4'd9) begin
                  w_bad_nxt = 1'b1;
               end
               if (r_cnt == 2'd2) begin
                  w_cnt_nxt   = 2'd0;
                  w_state_nxt = S_CHECK;
               end else begin
                  w_cnt_nxt = r_cnt + 2'd1;
               end
            end
         end
         S_CHECK: begin
            if (r_bad || !w_hit) begin
               w_err_nxt   = 1'b1;
               w_bad_nxt   = 1'b0;
               w_state_nxt = S_IDLE;
            end else if (w_value_tgt == r_idx) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_tgt_nxt   = w_value_tgt;
               w_inc_nxt   = w_dir_inc;
               w_state_nxt = S_MOVE;
            end
         end
         S_MOVE: begin
            if (step_tick) begin
               w_idx_nxt = w_idx_step;
               if (w_idx_step == r_tgt) begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next index so code and degrees always change together.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_idx     <= 3'd0;
         r_tgt     <= 3'd0;
         r_inc     <= 1'b1;
         r_cnt     <= 2'd0;
         r_bad     <= 1'b0;
         r_h       <= 4'd0;
         r_t       <= 4'd0;
         r_o       <= 4'd0;
         r_one_hot <= 3'd0;
         r_degrees <= 9'd0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_idx     <= w_idx_nxt;
         r_tgt     <= w_tgt_nxt;
         r_inc     <= w_inc_nxt;
         r_cnt     <= w_cnt_nxt;
         r_bad     <= w_bad_nxt;
         r_h       <= w_h_nxt;
         r_t       <= w_t_nxt;
         r_o       <= w_o_nxt;
         r_one_hot <= f_gray(w_idx_nxt);
         r_degrees <= f_degrees(w_idx_nxt);
         r_done    <= w_done_nxt;
         r_err     <= w_err_nxt;
      end
   end

   assign digit_ready = (r_state == S_IDLE);
   assign busy        = (r_state != S_IDLE);
   assign one_hot     = r_one_hot;
   assign degrees     = r_degrees;
   assign done        = r_done;
   assign err         = r_err;

endmodule

// File: tb/tb_bcd_angle_stepper.sv
// tb/tb_bcd_angle_stepper.sv - randomized and directed bench for bcd_angle_stepper against a sector model
module tb_bcd_angle_stepper;

   logic       clk = 1'b0;
   logic       rst;
   logic       dv   [2];
   logic [3:0] dig  [2];
   logic       tick [2];
   logic       rdy  [2];
   logic [2:0] oh   [2];
   logic [8:0] deg  [2];
   logic       bsy  [2];
   logic       dn   [2];
   logic       er   [2];

   int n_cmp = 0;
   int n_bad = 0;
   int pos [2];
   bit sh [2] = '{1'b1, 1'b0};
   int gtab [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

   always #5 clk = ~clk;

   bcd_angle_stepper #(.SHORTEST(1'b1)) u_s1 (
      .clk(clk), .rst(rst), .digit_valid(dv[0]), .digit(dig[0]), .digit_ready(rdy[0]),
      .step_tick(tick[0]), .one_hot(oh[0]), .degrees(deg[0]), .busy(bsy[0]),
      .done(dn[0]), .err(er[0])
   );

   bcd_angle_stepper #(.SHORTEST(1'b0)) u_s0 (
      .clk(clk), .rst(rst), .digit_valid(dv[1]), .digit(dig[1]), .digit_ready(rdy[1]),
      .step_tick(tick[1]), .one_hot(oh[1]), .degrees(deg[1]), .busy(bsy[1]),
      .done(dn[1]), .err(er[1])
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_pos(input int u, input string tag);
      chk({tag, "_one_hot"}, 32'(oh[u]), 32'(gtab[pos[u]]));
      chk({tag, "_degrees"}, 32'(deg[u]), 32'(45 * pos[u]));
   endtask

   task automatic send(input int u, input int h, input int t, input int o);
      chk("ready_before_cmd", 32'(rdy[u]), 1);
      dv[u] = 1'b1;
      dig[u] = 4'(h);
      step();
      dig[u] = 4'(t);
      step();
      dig[u] = 4'(o);
      step();
      dv[u] = 1'b0;
      chk("busy_in_check", 32'(bsy[u]), 1);
      chk("ready_in_check", 32'(rdy[u]), 0);
   endtask

   // Model: a command is a target sector; the move is a walk of unit steps in the chosen direction.
   task automatic run_cmd(input int u, input int h, input int t, input int o,
                          input bit always_tick, input bit hold_dv);
      int  v, tgt, cycles;
      bit  valid, up, tk;
      send(u, h, t, o);
      step();
      v = h * 100 + t * 10 + o;
      valid = (h <= 9) && (t <= 9) && (o <= 9) && (v <= 315) && (v % 45 == 0);
      if (!valid) begin
         chk("reject_err", 32'(er[u]), 1);
         chk("reject_done", 32'(dn[u]), 0);
         chk("reject_busy", 32'(bsy[u]), 0);
         check_pos(u, "reject");
      end else begin
         tgt = v / 45;
         if (tgt == pos[u]) begin
            chk("same_done", 32'(dn[u]), 1);
            chk("same_err", 32'(er[u]), 0);
            chk("same_busy", 32'(bsy[u]), 0);
            check_pos(u, "same");
         end else begin
            chk("move_start_busy", 32'(bsy[u]), 1);
            chk("move_start_done", 32'(dn[u]), 0);
            chk("move_start_err", 32'(er[u]), 0);
            up = !sh[u] || (((tgt - pos[u] + 8) % 8) <= 4);
            cycles = 0;
            forever begin
               tk = always_tick ? 1'b1 : 1'($urandom_range(0, 1));
               tick[u] = tk;
               if (hold_dv) begin
                  dv[u] = 1'b1;
                  dig[u] = 4'($urandom_range(0, 15));
               end
               step();
               if (tk) pos[u] = up ? (pos[u] + 1) % 8 : (pos[u] + 7) % 8;
               check_pos(u, "move");
               chk("move_err", 32'(er[u]), 0);
               if (pos[u] == tgt) begin
                  chk("move_done", 32'(dn[u]), 1);
                  chk("move_end_busy", 32'(bsy[u]), 0);
                  break;
               end
               chk("move_no_done", 32'(dn[u]), 0);
               chk("move_ready", 32'(rdy[u]), 0);
               cycles++;
               if (cycles > 200) begin
                  chk("move_timeout", 0, 1);
                  break;
               end
            end
            tick[u] = 1'b0;
            dv[u] = 1'b0;
         end
      end
      tick[u] = 1'($urandom_range(0, 1));
      step();
      tick[u] = 1'b0;
      chk("after_done", 32'(dn[u]), 0);
      chk("after_err", 32'(er[u]), 0);
      check_pos(u, "idle_tick");
   endtask

   initial begin
      int v, k;
      rst = 1'b1;
      for (int u = 0; u < 2; u++) begin
         dv[u] = 1'b0;
         dig[u] = 4'd0;
         tick[u] = 1'b0;
         pos[u] = 0;
      end
      step();
      step();
      rst = 1'b0;
      tick[0] = 1'b1;
      step();
      tick[0] = 1'b0;
      for (int u = 0; u < 2; u++) begin
         check_pos(u, "reset");
         chk("reset_ready", 32'(rdy[u]), 1);
         chk("reset_busy", 32'(bsy[u]), 0);
         chk("reset_done", 32'(dn[u]), 0);
         chk("reset_err", 32'(er[u]), 0);
      end

      run_cmd(0, 1, 3, 5, 1'b1, 1'b0);
      run_cmd(0, 3, 1, 5, 1'b1, 1'b0);
      run_cmd(0, 0, 4, 5, 1'b1, 1'b0);
      run_cmd(0, 2, 7, 0, 1'b1, 1'b0);
      run_cmd(0, 1, 0, 0, 1'b0, 1'b0);
      run_cmd(0, 0, 9, 0, 1'b0, 1'b0);
      run_cmd(0, 3, 6, 0, 1'b0, 1'b0);
      run_cmd(0, 1, 8, 0, 1'b0, 1'b1);
      run_cmd(0, 0, 12, 0, 1'b0, 1'b0);
      run_cmd(0, 1, 8, 0, 1'b0, 1'b0);
      run_cmd(1, 0, 4, 5, 1'b1, 1'b0);
      run_cmd(1, 2, 7, 0, 1'b1, 1'b0);

      // Abort mid-move on unit 1 while unit 0 holds a partial digit entry.
      run_cmd(1, 0, 0, 0, 1'b1, 1'b0);
      send(1, 2, 2, 5);
      step();
      dv[0] = 1'b1;
      dig[0] = 4'd3;
      tick[1] = 1'b1;
      step();
      dv[0] = 1'b0;
      step();
      pos[1] = 2;
      check_pos(1, "pre_reset");
      rst = 1'b1;
      step();
      rst = 1'b0;
      tick[1] = 1'b0;
      pos[0] = 0;
      pos[1] = 0;
      for (int u = 0; u < 2; u++) begin
         check_pos(u, "mid_reset");
         chk("mid_reset_busy", 32'(bsy[u]), 0);
         chk("mid_reset_done", 32'(dn[u]), 0);
         chk("mid_reset_ready", 32'(rdy[u]), 1);
      end
      run_cmd(0, 0, 9, 0, 1'b1, 1'b0);

      for (int n = 0; n < 40; n++) begin
         int u;
         u = n % 2;
         if ($urandom_range(0, 4) == 0) begin
            run_cmd(u, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                    1'b0, 1'($urandom_range(0, 1)));
         end else begin
            k = $urandom_range(0, 7);
            v = 45 * k;
            run_cmd(u, v / 100, (v / 10) % 10, v % 10, 1'b0, 1'($urandom_range(0, 1)));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
